br_checkpoint_ctrl: RTL and testbench
=====================================

Name: br_checkpoint_ctrl

Overview:
- Branch checkpoint controller for the physical-register free list in the R10000-style pipeline.
- On each dispatched branch it allocates a branch tag and snapshots the free-list tail index supplied by the free list.
- On a mispredict it drives the free list's rollback request and rollback index, and squashes all younger checkpoints.
- On a correct resolve it retires checkpoints in age order.

Parameters:
- NUM_BR, 4, number of checkpoint entries; power of two, ≥2.
- NUM_FL, 32, free-list depth; snapshot width FLW = $clog2(NUM_FL).
- BRW, $clog2(NUM_BR), branch tag width.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- br_dispatch_en  input  1  a branch dispatches this cycle
- fl_idx  input  FLW  free-list tail after this cycle's dispatch (FL_idx)
- br_resolve_en  input  1  a branch resolved as correctly predicted
- br_resolve_tag  input  BRW  tag of the correct branch
- br_mispredict_en  input  1  a branch resolved as mispredicted
- br_mispredict_tag  input  BRW  tag of the mispredicted branch
- br_tag  output  BRW  tag allocated to the dispatching branch (the current tail)
- br_stall  output  1  all entries are live; no branch may dispatch
- br_mask  output  NUM_BR  live-checkpoint bitmask
- rollback_en  output  1  free-list rollback request
- FL_rollback_idx  output  FLW  restored free-list tail

Behaviour:
- State:
  - Circular age-ordered buffer: snapshot[NUM_BR] (FLW each), valid[NUM_BR], resolved[NUM_BR].
  - Pointers head (oldest) and tail (next allocation), each BRW wide.
  - count, BRW+1 wide.
- Reset: head=tail=0, count=0, all valid and resolved cleared. Outputs after reset: br_tag=0, br_stall=0, br_mask=0, rollback_en=0, FL_rollback_idx=0.
- Combinational outputs:
  - br_tag = tail.
  - br_stall = (count == NUM_BR).
  - br_mask = valid.
  - mis_ok = br_mispredict_en && valid[br_mispredict_tag].
  - rollback_en = mis_ok; FL_rollback_idx = mis_ok ? snapshot[br_mispredict_tag] : 0.
  - Rollback is seen by the free list in the same cycle: zero latency.
- Allocate, when br_dispatch_en && !br_stall && !mis_ok:
  - snapshot[tail] <= fl_idx; valid[tail] <= 1; resolved[tail] <= 0; tail <= tail+1 (wraps mod NUM_BR).
- Resolve, when br_resolve_en && valid[br_resolve_tag] and the tag is not squashed this cycle: resolved[tag] <= 1.
- Head retire, each cycle: if valid[head] && resolved[head], clear valid[head] and increment head.
  - At most one entry retires per cycle.
  - A tag resolved this cycle retires no earlier than the next cycle.
- Mispredict (mis_ok), tag m:
  - Clear valid for m and every entry younger than m, i.e. indices m..tail-1 in circular order.
  - tail <= m; count <= age offset of m from head (m - head mod NUM_BR, 0 if m == head).
  - If m == head, head does not retire that cycle.
- Simultaneous events:
  - Mispredict beats dispatch: the dispatch is dropped and br_tag is not consumed.
  - Resolve of a tag older than m is applied; resolve of m or of a younger tag is ignored.
  - Resolve and mispredict on the same tag: mispredict wins.
  - Dispatch and head retire in the same cycle while full: dispatch still stalls, because br_stall uses the registered count.
- Invalid tags:
  - Resolve or mispredict naming a non-valid tag is ignored; no rollback_en.
- count:
  - +1 on allocate, -1 on retire, both in one cycle → unchanged.
  - A mispredict overrides count as above.
- Reset mid-operation: all state cleared regardless of inputs in that cycle.

Test Plan:
- Reset, then 4 dispatches with fl_idx=3,5,7,9 → br_tag 0,1,2,3; br_mask=1111; br_stall=1. A 5th dispatch is ignored and tail stays 0.
- From that full state, mispredict tag 1 → same-cycle rollback_en=1, FL_rollback_idx=5; next cycle br_mask=0001, br_tag=1, br_stall=0.
- Resolve tag 0 at cycle t → br_mask bit0 clears at t+2 (resolved at t+1, retired at the t+1 edge). Resolve tag 2 before tag 1 → no retire until tag 1 resolves, then tags 1 and 2 retire on consecutive cycles.
- Same cycle: dispatch (fl_idx=12) + mispredict tag 2 + resolve tag 0 → rollback to snapshot[2]; dispatch dropped; tag 0 retires later; br_tag=2.
- Wrap-around: allocate and retire 6 branches so tail wraps to 2 → snapshots and tags stay correct. Mispredict the oldest entry with head=3 → br_mask=0000, tail=3.
- Mispredict or resolve on a non-valid tag → rollback_en=0 and no state change. Reset asserted mid-stream → next cycle br_mask=0, br_tag=0.

Source files
------------

// File: rtl/br_checkpoint_ctrl.sv
// br_checkpoint_ctrl
//   Branch checkpoint controller for the physical-register free list.
//   Each dispatched branch gets a tag (a slot in a circular, age-ordered
//   buffer), and the slot stores the free-list tail index at dispatch.
//   A mispredict returns that stored index to the free list in the same
//   cycle and squashes the mispredicted branch and every younger one.
//   Correctly resolved branches retire from the head in age order.
//
// Ports
//   clock, reset       system clock, synchronous active-high reset
//   br_dispatch_en     a branch dispatches this cycle
//   fl_idx             free-list tail after this cycle's dispatch
//   br_resolve_en/tag  a branch resolved as correctly predicted
//   br_mispredict_en/tag  a branch resolved as mispredicted
//   br_tag             tag handed to the dispatching branch (current tail)
//   br_stall           every checkpoint is live; dispatch must wait
//   br_mask            live-checkpoint bitmask
//   rollback_en        free-list rollback request (combinational)
//   FL_rollback_idx    free-list tail to restore (0 when no rollback)
//
// Dispatch handshake: br_dispatch_en acts as valid and !br_stall as ready.
// A branch is taken (br_tag consumed) only on a cycle with both high and
// no accepted mispredict; a mispredict drops that cycle's dispatch.
module br_checkpoint_ctrl #(
  parameter int NUM_BR = 4,
  parameter int NUM_FL = 32,
  localparam int FLW = $clog2(NUM_FL),
  localparam int BRW = $clog2(NUM_BR)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           br_dispatch_en,
  input  logic [FLW-1:0] fl_idx,
  input  logic           br_resolve_en,
  input  logic [BRW-1:0] br_resolve_tag,
  input  logic           br_mispredict_en,
  input  logic [BRW-1:0] br_mispredict_tag,
  output logic [BRW-1:0] br_tag,
  output logic           br_stall,
  output logic [NUM_BR-1:0] br_mask,
  output logic           rollback_en,
  output logic [FLW-1:0] FL_rollback_idx
);

  logic [FLW-1:0]    snapshot [NUM_BR];
  logic [NUM_BR-1:0] valid, resolved;
  logic [BRW-1:0]    head, tail;
  logic [BRW:0]      count;

  logic [NUM_BR-1:0] valid_nxt, resolved_nxt, squash;
  logic [BRW-1:0]    head_nxt, tail_nxt;
  logic [BRW:0]      count_nxt;
  logic [BRW-1:0]    age [NUM_BR];
  logic [BRW-1:0]    mis_age, res_age, mis_off;
  logic              mis_ok, res_ok, alloc, retire;

  // Outputs
  assign br_tag          = tail;
  assign br_stall        = (count == (BRW+1)'(NUM_BR));
  assign br_mask         = valid;
  assign rollback_en     = mis_ok;
  assign FL_rollback_idx = mis_ok ? snapshot[br_mispredict_tag] : '0;

  always_comb begin
    mis_ok  = br_mispredict_en && valid[br_mispredict_tag];
    // Ages are offsets from head; valid entries always occupy ages 0..count-1,
    // so "younger or equal" is a plain compare even when the buffer is full
    // (where head == tail and the tail pointer alone is ambiguous).
    mis_age = br_mispredict_tag - head;
    res_age = br_resolve_tag - head;
    for (int i = 0; i < NUM_BR; i++) begin
      age[i]    = BRW'(i) - head;
      squash[i] = mis_ok && (age[i] >= mis_age);
    end
    res_ok = br_resolve_en && valid[br_resolve_tag] && !(mis_ok && (res_age >= mis_age));
    alloc  = br_dispatch_en && !br_stall && !mis_ok;
    // A squashed head is discarded by the squash, not retired.
    retire = valid[head] && resolved[head] && !(mis_ok && (br_mispredict_tag == head));

    head_nxt = retire ? head + BRW'(1) : head;

    valid_nxt    = valid;
    resolved_nxt = resolved;
    if (retire) begin
      valid_nxt[head]    = 1'b0;
      resolved_nxt[head] = 1'b0;
    end
    if (res_ok) resolved_nxt[br_resolve_tag] = 1'b1;
    valid_nxt    = valid_nxt & ~squash;
    resolved_nxt = resolved_nxt & ~squash;
    if (alloc) begin
      valid_nxt[tail]    = 1'b1;
      resolved_nxt[tail] = 1'b0;
    end

    // Surviving entries after a mispredict are exactly those between the
    // (possibly advanced) head and the mispredicted tag.
    mis_off = br_mispredict_tag - head_nxt;

    if (mis_ok) begin
      tail_nxt  = br_mispredict_tag;
      count_nxt = {1'b0, mis_off};
    end else begin
      tail_nxt = alloc ? tail + BRW'(1) : tail;
      unique case ({alloc, retire})
        2'b10:   count_nxt = count + (BRW+1)'(1);
        2'b01:   count_nxt = count - (BRW+1)'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      resolved <= '0;
      for (int i = 0; i < NUM_BR; i++) snapshot[i] <= '0;
    end else begin
      head     <= head_nxt;
      tail     <= tail_nxt;
      count    <= count_nxt;
      valid    <= valid_nxt;
      resolved <= resolved_nxt;
      if (alloc) snapshot[tail] <= fl_idx;
    end
  end

endmodule

// File: tb/tb_br_checkpoint_ctrl.sv
module tb_br_checkpoint_ctrl;

  localparam int NUM_BR = 4;
  localparam int NUM_FL = 32;
  localparam int FLW = $clog2(NUM_FL);
  localparam int BRW = $clog2(NUM_BR);

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic           br_dispatch_en = 1'b0;
  logic [FLW-1:0] fl_idx = '0;
  logic           br_resolve_en = 1'b0;
  logic [BRW-1:0] br_resolve_tag = '0;
  logic           br_mispredict_en = 1'b0;
  logic [BRW-1:0] br_mispredict_tag = '0;
  logic [BRW-1:0] br_tag;
  logic           br_stall;
  logic [NUM_BR-1:0] br_mask;
  logic           rollback_en;
  logic [FLW-1:0] FL_rollback_idx;

  int n_checks = 0;
  int n_fail   = 0;

  br_checkpoint_ctrl #(.NUM_BR(NUM_BR), .NUM_FL(NUM_FL)) dut (
    .clock             (clock),
    .reset             (reset),
    .br_dispatch_en    (br_dispatch_en),
    .fl_idx            (fl_idx),
    .br_resolve_en     (br_resolve_en),
    .br_resolve_tag    (br_resolve_tag),
    .br_mispredict_en  (br_mispredict_en),
    .br_mispredict_tag (br_mispredict_tag),
    .br_tag            (br_tag),
    .br_stall          (br_stall),
    .br_mask           (br_mask),
    .rollback_en       (rollback_en),
    .FL_rollback_idx   (FL_rollback_idx)
  );

  // Driver tasks: inputs change 1ns after the rising edge, outputs are
  // sampled 1ns after inputs settle, well away from the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    br_dispatch_en   = 1'b0;
    br_resolve_en    = 1'b0;
    br_mispredict_en = 1'b0;
  endtask

  task automatic dispatch(input int fl);
    br_dispatch_en = 1'b1;
    fl_idx         = FLW'(fl);
  endtask

  task automatic resolve(input int tag);
    br_resolve_en  = 1'b1;
    br_resolve_tag = BRW'(tag);
  endtask

  task automatic mispredict(input int tag);
    br_mispredict_en  = 1'b1;
    br_mispredict_tag = BRW'(tag);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int mask, input int tg, input int stall);
    chk({tag, ".mask"},  32'(br_mask),  32'(mask));
    chk({tag, ".tag"},   32'(br_tag),   32'(tg));
    chk({tag, ".stall"}, 32'(br_stall), 32'(stall));
  endtask

  initial begin
    // Reset
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk_state("reset", 0, 0, 0);
    chk("reset.rb_en",  32'(rollback_en),     32'd0);
    chk("reset.rb_idx", 32'(FL_rollback_idx), 32'd0);

    // Fill all four checkpoints with fl_idx 3,5,7,9
    for (int i = 0; i < 4; i++) begin
      dispatch(3 + 2 * i);
      #1;
      chk("fill.tag", 32'(br_tag), 32'(i));
      tick();
    end
    idle(); #1;
    chk_state("full", 4'hF, 0, 1);

    // Fifth dispatch while full is ignored
    dispatch(20);
    tick(); idle(); #1;
    chk_state("full_drop", 4'hF, 0, 1);

    // Mispredict tag 1 from full: same-cycle rollback to 5
    mispredict(1);
    #1;
    chk("mis1.rb_en",  32'(rollback_en),     32'd1);
    chk("mis1.rb_idx", 32'(FL_rollback_idx), 32'd5);
    tick(); idle(); #1;
    chk_state("mis1.after", 4'b0001, 1, 0);

    // Refill tags 1 and 2 (fl 11, 13)
    dispatch(11); tick();
    dispatch(13); tick();
    idle(); #1;
    chk_state("refill", 4'b0111, 3, 0);

    // Resolve tag 0: resolved at the first edge, retired at the second
    resolve(0);
    tick(); idle(); #1;
    chk("res0.t1", 32'(br_mask), 32'h7);
    tick();
    chk("res0.t2", 32'(br_mask), 32'h6);

    // Out-of-order resolve: tag 2 first holds until tag 1 resolves
    resolve(2);
    tick(); idle(); #1;
    chk("res2.hold_a", 32'(br_mask), 32'h6);
    tick();
    chk("res2.hold_b", 32'(br_mask), 32'h6);
    resolve(1);
    tick(); idle(); #1;
    chk("res1.t1", 32'(br_mask), 32'h6);
    tick();
    chk("res1.retire1", 32'(br_mask), 32'h4);
    tick();
    chk_state("res1.retire2", 0, 3, 0);

    // Clean restart, tags 0..2 with fl 3,5,7
    reset = 1'b1; tick(); reset = 1'b0;
    dispatch(3); tick();
    dispatch(5); tick();
    dispatch(7); tick();
    idle();

    // Same cycle: dispatch(12) + mispredict 2 + resolve 0
    dispatch(12); mispredict(2); resolve(0);
    #1;
    chk("combo.rb_en",  32'(rollback_en),     32'd1);
    chk("combo.rb_idx", 32'(FL_rollback_idx), 32'd7);
    chk("combo.tag",    32'(br_tag),          32'd3);
    tick(); idle(); #1;
    chk_state("combo.after", 4'b0011, 2, 0);
    tick();
    chk("combo.retire0", 32'(br_mask), 32'h2);

    // Mispredict a non-valid tag: no rollback, no change
    mispredict(3);
    #1;
    chk("inv_mis.rb_en",  32'(rollback_en),     32'd0);
    chk("inv_mis.rb_idx", 32'(FL_rollback_idx), 32'd0);
    tick(); idle(); #1;
    chk_state("inv_mis.after", 4'b0010, 2, 0);

    // Resolve a non-valid tag: no change
    resolve(0);
    tick(); idle(); #1;
    tick();
    chk_state("inv_res.after", 4'b0010, 2, 0);

    // Mispredict the head (tag 1): snapshot 5 survived the earlier events
    mispredict(1);
    #1;
    chk("mis_head.rb_idx", 32'(FL_rollback_idx), 32'd5);
    tick(); idle(); #1;
    chk_state("mis_head.after", 0, 1, 0);

    // Wrap-around: six allocate/resolve/retire rounds starting at tag 1
    for (int k = 0; k < 6; k++) begin
      dispatch(16 + k);
      #1;
      chk("wrap.tag", 32'(br_tag), 32'((1 + k) % 4));
      tick(); idle();
      resolve((1 + k) % 4);
      tick(); idle(); #1;
      tick();
      chk("wrap.empty", 32'(br_mask), 32'd0);
    end

    // head = tail = 3; allocate tags 3,0,1 so tail wraps to 2
    dispatch(30); tick();
    dispatch(31); tick();
    dispatch(32); tick();
    idle(); #1;
    chk_state("wrap.fill", 4'b1011, 2, 0);

    // Mispredict wrapped tag 1: rollback 32, tags 3 and 0 survive
    mispredict(1);
    #1;
    chk("wrap.mis1.rb_idx", 32'(FL_rollback_idx), 32'd32 % NUM_FL);
    tick(); idle(); #1;
    chk_state("wrap.mis1.after", 4'b1001, 1, 0);

    // Mispredict the oldest (tag 3 at head): everything squashed
    mispredict(3);
    #1;
    chk("wrap.mis3.rb_idx", 32'(FL_rollback_idx), 32'd30);
    tick(); idle(); #1;
    chk_state("wrap.mis3.after", 0, 3, 0);

    // Full buffer with the head retiring: dispatch still stalls
    dispatch(8); tick();
    dispatch(9); tick();
    dispatch(10); tick();
    dispatch(11); tick();
    idle();
    resolve(3);
    tick(); idle();
    dispatch(25);
    #1;
    chk("full_retire.stall", 32'(br_stall), 32'd1);
    tick(); idle(); #1;
    chk_state("full_retire.after", 4'b0111, 3, 0);

    // Reset mid-stream with activity on the inputs
    reset = 1'b1;
    dispatch(14); mispredict(0); resolve(1);
    tick();
    reset = 1'b0;
    idle(); #1;
    chk_state("mid_reset", 0, 0, 0);
    chk("mid_reset.rb_en", 32'(rollback_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
